grey_display_scan: RTL
======================

Name: grey_display_scan

Overview:
- Downstream consumer of the 12-digit decimal counter.
- Takes the counter's twelve 5-bit one-step digit codes (hunB..ones) and time-multiplexes them onto a single 7-segment driver with one-hot digit enables.
- Handles leading-zero blanking, a thousands-separator decimal point, and invalid-code flagging.
- Captures a coherent snapshot once per frame so a ripple carry never tears the display.

Parameters:
- DWELL, 4: clock cycles each digit stays enabled; legal range 1..255.
- BLANK_LZ, 1: 1 enables leading-zero blanking; 0 shows all twelve digits.

Ports:
- i_clk  in  1  system clock; all state on rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_digits  in  60  packed codes: [59:55] hunB, [54:50] tenB, [49:45] bil, [44:40] hunM, [39:35] tenM, [34:30] mil, [29:25] hunT, [24:20] tenT, [19:15] thou, [14:10] hund, [9:5] tens, [4:0] ones. Digit index k sits at [5k+4:5k].
- i_hold  in  1  1 = LOAD does not recapture; previous snapshot is re-shown.
- o_seg  out  7  segments {g,f,e,d,c,b,a}, active high.
- o_dp  out  1  decimal point, active high.
- o_dig  out  12  one-hot digit enable; bit k = digit index k.
- o_bcd  out  4  binary value of the enabled digit; 4'hF when invalid.
- o_frame  out  1  one-cycle pulse during LOAD.
- o_err  out  1  sticky: set when an invalid code is displayed.

Behaviour:
- Clock and reset: one clock (i_clk). Reset is synchronous and active-low (i_rst_n).
- Reset (i_rst_n=0 at a clock edge):
  - state=LOAD, idx=11, dwell=0, lz=1, snapshot=0, o_err=0.
  - All outputs are driven from flops or decoded from them; while in reset every output is 0.
- LOAD state (exactly 1 cycle):
  - snapshot<=i_digits unless i_hold=1.
  - lz<=1, idx<=11, dwell<=0.
  - o_dig=0, o_seg=0, o_dp=0, o_bcd=0, o_frame=1.
  - Next state is SHOW.
- SHOW state:
  - o_dig=1<<idx; dwell counts 0..DWELL-1.
  - At dwell=DWELL-1:
    - if idx=0, go to LOAD;
    - else idx<=idx-1, dwell<=0, and lz<=lz & (code(idx)==5'b00000).
  - Frame length = 1 + 12*DWELL cycles. Scan order is index 11 (hunB) down to 0 (ones).
- Decode (code -> value / o_seg hex):
  - 00000->0/3F, 00001->1/06, 00011->2/5B, 00010->3/4F, 00110->4/66
  - 00100->5/6D, 01100->6/7D, 01000->7/07, 11000->8/7F, 10000->9/6F
  - Any other code -> o_bcd=F, o_seg=79 ("E").
- Invalid codes:
  - o_err sets on the first SHOW cycle of an invalid digit.
  - o_err clears only on reset.
  - An invalid digit also clears lz at its advance, since it counts as nonzero.
- Blanking:
  - Condition: BLANK_LZ=1 & lz=1 & code==00000 & idx!=0.
  - Effect: o_seg=0 and o_dp=0. o_dig is still asserted and o_bcd=0.
  - The ones digit is never blanked.
- Decimal point: o_dp=1 in SHOW when idx is 9, 6 or 3 (bil, mil, thou) and the digit is not blanked.
- Snapshot timing: i_digits changes outside LOAD have no effect until the next LOAD.
- i_hold: i_hold=1 in LOAD keeps the old snapshot. The sampling point is LOAD only.
- Reset mid-frame: takes effect at the next edge and restarts from LOAD. No partial digit completes.
- DWELL=1: each digit is shown for one cycle; frame = 13 cycles.

Test Plan:
- Reset, then i_digits with ones=00110 and all others 0, DWELL=2, BLANK_LZ=1:
  - o_frame=1 on cycle 0;
  - digits 11..1 each enabled 2 cycles with o_seg=00;
  - ones: o_dig=001, o_seg=66, o_bcd=4;
  - next LOAD at cycle 25.
- i_digits = bil=00001 (index 9), others 0 -> idx 11,10 blank; idx 9 o_seg=06, o_dp=1; idx 8..1 o_seg=3F; idx 6 and 3 o_dp=1; idx 0 o_seg=3F.
- Change i_digits mid-SHOW -> displayed values unchanged until after the next LOAD. With i_hold=1 at that LOAD, the old values persist for the whole following frame.
- Index 5 = 11111 -> when idx=5: o_seg=79, o_bcd=F, o_err rises and stays 1 across later frames. Higher zero digits are blanked; lower zeros show 3F.
- BLANK_LZ=0, all zero -> all 12 digits show 3F; o_dp at idx 9, 6, 3.
- Assert i_rst_n=0 at idx=7 for one cycle -> next cycle: all outputs 0, o_err=0. The following cycle is LOAD with o_frame=1, then idx=11.

Source files
------------

// File: rtl/grey_display_scan.sv
// Time-multiplexed 12-digit 7-segment scanner for the Gray-coded decimal counter.
// A snapshot is taken once per frame in LOAD, then digits are shown MSB (hunB) to LSB (ones).
`timescale 1ns/1ps

module grey_display_scan #(
  parameter int DWELL    = 4,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [59:0] i_digits,
  input  logic        i_hold,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic [11:0] o_dig,
  output logic [3:0]  o_bcd,
  output logic        o_frame,
  output logic        o_err
);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  // Handshake-free block: i_digits/i_hold are level inputs sampled only in a
  // running LOAD cycle; outputs are combinational decodes of the registers.
  state_t      r_state;
  logic        r_run;
  logic [3:0]  r_idx;
  logic [7:0]  r_dwell;
  logic        r_lz;
  logic [59:0] r_snap;
  logic        r_err;

  state_t      w_state_nx;
  logic [3:0]  w_idx_nx;
  logic [7:0]  w_dwell_nx;
  logic        w_lz_nx;
  logic [59:0] w_snap_nx;

  logic [4:0]  w_code;
  logic [3:0]  w_val;
  logic [6:0]  w_seg;
  logic        w_valid;
  logic        w_show;
  logic        w_load;
  logic        w_blank;
  logic        w_dp_pos;
  logic        w_last;

  // r_run keeps every output at zero for the cycle right after reset, so the
  // first visible LOAD comes one cycle after reset is released.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_LOAD;
      r_run   <= 1'b0;
      r_idx   <= 4'd11;
      r_dwell <= 8'd0;
      r_lz    <= 1'b1;
      r_snap  <= 60'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_run   <= 1'b1;
      r_idx   <= w_idx_nx;
      r_dwell <= w_dwell_nx;
      r_lz    <= w_lz_nx;
      r_snap  <= w_snap_nx;
      if (w_show && !w_valid) r_err <= 1'b1;
    end
  end

  always_comb begin
    w_code = 5'd0;
    for (int k = 0; k < 12; k++) begin
      if (r_idx == 4'(k)) w_code = r_snap[5*k +: 5];
    end
  end

  always_comb begin
    w_val   = 4'hF;
    w_seg   = 7'h79;
    w_valid = 1'b1;
    case (w_code)
      5'b00000: begin w_val = 4'd0; w_seg = 7'h3F; end
      5'b00001: begin w_val = 4'd1; w_seg = 7'h06; end
      5'b00011: begin w_val = 4'd2; w_seg = 7'h5B; end
      5'b00010: begin w_val = 4'd3; w_seg = 7'h4F; end
      5'b00110: begin w_val = 4'd4; w_seg = 7'h66; end
      5'b00100: begin w_val = 4'd5; w_seg = 7'h6D; end
      5'b01100: begin w_val = 4'd6; w_seg = 7'h7D; end
      5'b01000: begin w_val = 4'd7; w_seg = 7'h07; end
      5'b11000: begin w_val = 4'd8; w_seg = 7'h7F; end
      5'b10000: begin w_val = 4'd9; w_seg = 7'h6F; end
      default:  w_valid = 1'b0;
    endcase
  end

  assign w_load   = r_run && (r_state == ST_LOAD);
  assign w_show   = r_run && (r_state == ST_SHOW);
  assign w_blank  = BLANK_LZ && r_lz && (w_code == 5'd0) && (r_idx != 4'd0);
  assign w_dp_pos = (r_idx == 4'd9) || (r_idx == 4'd6) || (r_idx == 4'd3);
  assign w_last   = (r_dwell == DWELL_LAST);

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_dwell_nx = r_dwell;
    w_lz_nx    = r_lz;
    w_snap_nx  = r_snap;
    if (!r_run) begin
      w_state_nx = ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (!i_hold) w_snap_nx = i_digits;
          w_lz_nx    = 1'b1;
          w_idx_nx   = 4'd11;
          w_dwell_nx = 8'd0;
          w_state_nx = ST_SHOW;
        end
        ST_SHOW: begin
          if (w_last) begin
            if (r_idx == 4'd0) begin
              w_state_nx = ST_LOAD;
            end else begin
              w_idx_nx   = r_idx - 4'd1;
              w_dwell_nx = 8'd0;
              // Invalid codes are nonzero, so they end leading-zero blanking too.
              w_lz_nx    = r_lz && (w_code == 5'd0);
            end
          end else begin
            w_dwell_nx = r_dwell + 8'd1;
          end
        end
        default: w_state_nx = ST_LOAD;
      endcase
    end
  end

  always_comb begin
    o_seg   = 7'h00;
    o_dp    = 1'b0;
    o_dig   = 12'h000;
    o_bcd   = 4'h0;
    o_frame = w_load;
    o_err   = r_err || (w_show && !w_valid);
    if (w_show) begin
      o_dig = 12'd1 << r_idx;
      if (!w_blank) begin
        o_seg = w_seg;
        o_bcd = w_valid ? w_val : 4'hF;
        o_dp  = w_dp_pos;
      end
    end
  end

endmodule
